// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: carries one instruction slot (instruction, PC,
// operand lanes, control bundle) from one pipeline stage to the next.
// Supports flush-to-bubble, hold with Tnew aging, and counts bubble cycles.
module pipe_stage_reg #(
  parameter int          NUM_LANES = 2,
  parameter int          CTRL_LEN  = 31,
  parameter int          TNEW_LSB  = 8,
  parameter int          TNEW_W    = 3,
  parameter bit          OUT_DEC   = 1'b1,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          CNT_W     = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Flush,
  input  logic                      Hold,
  input  logic                      ValidIn,
  input  logic [31:0]               InsIn,
  input  logic [31:0]               PCIn,
  input  logic [32*NUM_LANES-1:0]   DataIn,
  input  logic [CTRL_LEN-1:0]       CtrlIn,
  output logic                      ValidOut,
  output logic [31:0]               InsOut,
  output logic [31:0]               PCOut,
  output logic [32*NUM_LANES-1:0]   DataOut,
  output logic [CTRL_LEN-1:0]       CtrlOut,
  output logic [CNT_W-1:0]          BubbleCnt
);

  localparam int DATA_W = 32 * NUM_LANES;

  // Reject parameter sets where the Tnew field does not fit or there are no lanes.
  if ((TNEW_LSB + TNEW_W > CTRL_LEN) || (NUM_LANES < 1)) begin : g_param_err
    $error("pipe_stage_reg: illegal parameters (Tnew field outside control bundle or NUM_LANES < 1)");
  end

  // One action per edge, resolved from Flush > Hold > Load.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_BUBBLE = 2'd3
  } action_e;

  // Unsigned Tnew decrement that stops at zero instead of wrapping.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    logic [TNEW_W-1:0] r;
    if (t == {TNEW_W{1'b0}}) begin
      r = {TNEW_W{1'b0}};
    end else begin
      r = t - TNEW_W'(1);
    end
    return r;
  endfunction

  // Extract the Tnew field from a control bundle.
  function automatic logic [TNEW_W-1:0] get_tnew(input logic [CTRL_LEN-1:0] c);
    return c[TNEW_LSB +: TNEW_W];
  endfunction

  // Replace the Tnew field of a control bundle, leaving all other bits alone.
  function automatic logic [CTRL_LEN-1:0] set_tnew(input logic [CTRL_LEN-1:0] c,
                                                   input logic [TNEW_W-1:0]   t);
    logic [CTRL_LEN-1:0] r;
    r = c;
    r[TNEW_LSB +: TNEW_W] = t;
    return r;
  endfunction

  logic                valid_q, valid_d;
  logic [31:0]         ins_q,   ins_d;
  logic [31:0]         pc_q,    pc_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic [CTRL_LEN-1:0] ctrl_q,  ctrl_d;
  logic [CNT_W-1:0]    bcnt_q,  bcnt_d;
  action_e             act_s;
  logic                bubble_s;

  // Resolve the action for this edge; an invalid upstream slot loads a bubble.
  always_comb begin
    act_s = ACT_LOAD;
    if (Flush) begin
      act_s = ACT_FLUSH;
    end else if (Hold) begin
      act_s = ACT_HOLD;
    end else if (!ValidIn) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  // Compute next slot contents for the selected action.
  always_comb begin
    valid_d = valid_q;
    ins_d   = ins_q;
    pc_d    = pc_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    case (act_s)
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d = 1'b0;
        ins_d   = 32'h0000_0000;
        pc_d    = RESET_PC;
        data_d  = {DATA_W{1'b0}};
        ctrl_d  = {CTRL_LEN{1'b0}};
      end
      ACT_HOLD: begin
        // Holding ages the stored result-ready distance by one cycle.
        ctrl_d = set_tnew(ctrl_q, tnew_dec(get_tnew(ctrl_q)));
      end
      ACT_LOAD: begin
        valid_d = 1'b1;
        ins_d   = InsIn;
        pc_d    = PCIn;
        data_d  = DataIn;
        ctrl_d  = CtrlIn;
      end
      default: begin
        valid_d = 1'b0;
        ins_d   = 32'h0000_0000;
        pc_d    = RESET_PC;
        data_d  = {DATA_W{1'b0}};
        ctrl_d  = {CTRL_LEN{1'b0}};
      end
    endcase
  end

  // Count edges that leave the stage empty, including holding an empty stage.
  always_comb begin
    bubble_s = 1'b0;
    case (act_s)
      ACT_FLUSH, ACT_BUBBLE: bubble_s = 1'b1;
      ACT_HOLD:              bubble_s = ~valid_q;
      ACT_LOAD:              bubble_s = 1'b0;
      default:               bubble_s = 1'b0;
    endcase
    if (bubble_s && (bcnt_q != {CNT_W{1'b1}})) begin
      bcnt_d = bcnt_q + CNT_W'(1);
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  // Slot and counter state; reset forces an empty slot at once and clears the count.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= 1'b0;
      ins_q   <= 32'h0000_0000;
      pc_q    <= RESET_PC;
      data_q  <= {DATA_W{1'b0}};
      ctrl_q  <= {CTRL_LEN{1'b0}};
      bcnt_q  <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Outputs come straight from stored state; only the Tnew view may be aged.
  always_comb begin
    ValidOut  = valid_q;
    InsOut    = ins_q;
    PCOut     = pc_q;
    DataOut   = data_q;
    BubbleCnt = bcnt_q;
    if (OUT_DEC) begin
      CtrlOut = set_tnew(ctrl_q, tnew_dec(get_tnew(ctrl_q)));
    end else begin
      CtrlOut = ctrl_q;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: default instance plus a swept
// instance (3 lanes, Tnew at bit 0, 4-bit bubble counter).
module tb_pipe_stage_reg;

  logic        Clk;
  logic        Reset;

  // Default-parameter instance signals.
  logic        flush, hold, valid_in;
  logic [31:0] ins_in, pc_in;
  logic [63:0] data_in;
  logic [30:0] ctrl_in;
  logic        valid_out;
  logic [31:0] ins_out, pc_out;
  logic [63:0] data_out;
  logic [30:0] ctrl_out;
  logic [15:0] bcnt;

  // Swept instance signals.
  logic        s_flush, s_hold, s_valid_in;
  logic [31:0] s_ins_in, s_pc_in;
  logic [95:0] s_data_in;
  logic [30:0] s_ctrl_in;
  logic        s_valid_out;
  logic [31:0] s_ins_out, s_pc_out;
  logic [95:0] s_data_out;
  logic [30:0] s_ctrl_out;
  logic [3:0]  s_bcnt;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stage_reg u_dut (
    .Clk(Clk), .Reset(Reset), .Flush(flush), .Hold(hold), .ValidIn(valid_in),
    .InsIn(ins_in), .PCIn(pc_in), .DataIn(data_in), .CtrlIn(ctrl_in),
    .ValidOut(valid_out), .InsOut(ins_out), .PCOut(pc_out), .DataOut(data_out),
    .CtrlOut(ctrl_out), .BubbleCnt(bcnt)
  );

  pipe_stage_reg #(.NUM_LANES(3), .TNEW_LSB(0), .CNT_W(4)) u_sw (
    .Clk(Clk), .Reset(Reset), .Flush(s_flush), .Hold(s_hold), .ValidIn(s_valid_in),
    .InsIn(s_ins_in), .PCIn(s_pc_in), .DataIn(s_data_in), .CtrlIn(s_ctrl_in),
    .ValidOut(s_valid_out), .InsOut(s_ins_out), .PCOut(s_pc_out), .DataOut(s_data_out),
    .CtrlOut(s_ctrl_out), .BubbleCnt(s_bcnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    flush = 1'b0; hold = 1'b0; valid_in = 1'b1;
    ins_in = 32'h0043_2021; pc_in = 32'h0000_3004;
    data_in = {32'h1111_2222, 32'h3333_4444};
    ctrl_in = 31'h4000_0201;
    s_flush = 1'b0; s_hold = 1'b0; s_valid_in = 1'b1;
    s_ins_in = 32'h1234_5678; s_pc_in = 32'h0000_3100;
    s_data_in = {32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    s_ctrl_in = 31'h0000_0A05;

    // Reset state, reached without a clock edge.
    #1 Reset = 1'b1;
    #1;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_pc",    pc_out,    32'h0000_3000);
    chk("rst_ins",   ins_out,   32'h0);
    chk("rst_ctrl",  ctrl_out,  31'h0);
    chk("rst_bcnt",  bcnt,      16'h0);

    // Edges are ignored while reset is high.
    step();
    chk("rst_ignore_valid", valid_out, 1'b0);
    chk("rst_ignore_pc",    pc_out,    32'h0000_3000);
    #2 Reset = 1'b0;

    // Load: Tnew=2 stored, shown as 1.
    step();
    chk("load_valid", valid_out, 1'b1);
    chk("load_ins",   ins_out,   32'h0043_2021);
    chk("load_pc",    pc_out,    32'h0000_3004);
    chk("load_data",  data_out,  64'h1111_2222_3333_4444);
    chk("load_ctrl",  ctrl_out,  31'h4000_0101);
    chk("load_bcnt",  bcnt,      16'h0);

    // Load Tnew=3, then hold four cycles with garbage on the inputs.
    ins_in = 32'h8C01_0004; pc_in = 32'h0000_3008; ctrl_in = 31'h4000_0301;
    step();
    chk("ld3_ctrl", ctrl_out, 31'h4000_0201);
    hold = 1'b1; ins_in = 32'hFFFF_FFFF; pc_in = 32'h0000_FFFC; ctrl_in = 31'h7FFF_FFFF;
    data_in = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    chk("hold1_ctrl", ctrl_out, 31'h4000_0101);
    chk("hold1_ins",  ins_out,  32'h8C01_0004);
    step();
    chk("hold2_ctrl", ctrl_out, 31'h4000_0001);
    chk("hold2_pc",   pc_out,   32'h0000_3008);
    step();
    chk("hold3_ctrl", ctrl_out, 31'h4000_0001);
    step();
    chk("hold4_ctrl",  ctrl_out,  31'h4000_0001);
    chk("hold4_ins",   ins_out,   32'h8C01_0004);
    chk("hold4_valid", valid_out, 1'b1);
    chk("hold4_data",  data_out,  64'h1111_2222_3333_4444);
    chk("hold4_bcnt",  bcnt,      16'h0);

    // Flush beats Hold.
    flush = 1'b1;
    step();
    chk("prio_valid", valid_out, 1'b0);
    chk("prio_pc",    pc_out,    32'h0000_3000);
    chk("prio_ins",   ins_out,   32'h0);
    chk("prio_data",  data_out,  64'h0);
    chk("prio_bcnt",  bcnt,      16'h1);

    // Holding a bubble still counts.
    flush = 1'b0;
    step();
    chk("holdbub_valid", valid_out, 1'b0);
    chk("holdbub_bcnt",  bcnt,      16'h2);

    // Bubble load ignores other inputs.
    hold = 1'b0; valid_in = 1'b0;
    step();
    chk("bub_ins",  ins_out,  32'h0);
    chk("bub_ctrl", ctrl_out, 31'h0);
    chk("bub_pc",   pc_out,   32'h0000_3000);
    chk("bub_bcnt", bcnt,     16'h3);

    // Valid load does not count.
    valid_in = 1'b1; ins_in = 32'h0000_0001; pc_in = 32'h0000_300C; ctrl_in = 31'h0000_0000;
    step();
    chk("ld_after_bub_valid", valid_out, 1'b1);
    chk("ld_after_bub_ctrl",  ctrl_out,  31'h0);
    chk("ld_after_bub_bcnt",  bcnt,      16'h3);

    // Asynchronous reset pulse between edges.
    Reset = 1'b1;
    #1;
    chk("arst_valid", valid_out, 1'b0);
    chk("arst_ins",   ins_out,   32'h0);
    chk("arst_pc",    pc_out,    32'h0000_3000);
    chk("arst_bcnt",  bcnt,      16'h0);
    #1 Reset = 1'b0;

    // First edge after reset uses normal priority.
    ins_in = 32'h0000_0002; pc_in = 32'h0000_3010;
    step();
    chk("post_rst_valid", valid_out, 1'b1);
    chk("post_rst_ins",   ins_out,   32'h0000_0002);
    chk("post_rst_bcnt",  bcnt,      16'h0);

    // Reset during a hold discards the held instruction.
    hold = 1'b1;
    step();
    chk("pre_mid_hold_valid", valid_out, 1'b1);
    Reset = 1'b1;
    #2 Reset = 1'b0;
    chk("midhold_valid", valid_out, 1'b0);
    step();
    chk("midhold_ins",  ins_out, 32'h0);
    chk("midhold_bcnt", bcnt,    16'h1);
    hold = 1'b0;

    // Swept instance: third lane and Tnew at [2:0].
    step();
    chk("sw_lane2", s_data_out[95:64], 32'hDEAD_BEEF);
    chk("sw_data",  s_data_out, 96'hDEAD_BEEF_2222_2222_1111_1111);
    chk("sw_ctrl",  s_ctrl_out, 31'h0000_0A04);
    s_hold = 1'b1;
    step();
    chk("sw_hold_ctrl", s_ctrl_out, 31'h0000_0A03);
    chk("sw_bcnt0",     s_bcnt,     4'h0);

    // Counter saturation on the 4-bit counter.
    s_hold = 1'b0; s_flush = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("sw_bcnt14", s_bcnt, 4'hE);
    for (int i = 0; i < 6; i++) step();
    chk("sw_bcnt_sat",  s_bcnt,      4'hF);
    chk("sw_sat_valid", s_valid_out, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter NUM_LANES, default 2: number of 32-bit operand lanes carried through the stage.
REQ-002 Parameter CTRL_LEN, default 31: width of the control bundle.
REQ-003 Parameter TNEW_LSB, default 8: bit position of the Tnew field LSB inside the control bundle.
REQ-004 Parameter TNEW_W, default 3: width of the Tnew field.
REQ-005 Parameter OUT_DEC, default 1: 1 means CtrlOut presents Tnew decremented by one, saturating at 0; 0 means stored Tnew is shown unchanged.
REQ-006 Parameter RESET_PC, default 32'h0000_3000: PC value of a bubble.
REQ-007 Parameter CNT_W, default 16: bubble counter width.
REQ-008 The clocking and reset ports SHALL be as listed below; there is one clock, and reset is asynchronous and active-high.
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Flush  in  1  load a bubble at the next edge.
- Hold  in  1  freeze the stage contents at the next edge.
- ValidIn  in  1  the upstream slot carries a real instruction.
- InsIn  in  32  instruction word.
- PCIn  in  32  instruction PC.
- DataIn  in  32*NUM_LANES  operand lanes; lane k occupies bits [32k+31:32k].
- CtrlIn  in  CTRL_LEN  control bundle.
- ValidOut  out  1  the stage holds a real instruction.
- InsOut  out  32  registered instruction.
- PCOut  out  32  registered PC.
- DataOut  out  32*NUM_LANES  registered lanes.
- CtrlOut  out  CTRL_LEN  registered control, with the Tnew field per REQ-005.
- BubbleCnt  out  CNT_W  count of bubble cycles.

Function
REQ-009 The stage SHALL apply exactly one action per rising edge, with priority Flush > Hold > Load.
REQ-010 On Flush, the stage SHALL load a bubble: ins=0, pc=RESET_PC, ctrl=0, all lanes=0, valid=0.
REQ-011 On Hold without Flush, the stage SHALL keep ins, pc, lanes, valid and every non-Tnew control bit unchanged.
REQ-012 On Hold without Flush, the stage SHALL decrement the stored Tnew by 1, saturating at 0.
REQ-013 On Load, the stage SHALL capture all inputs.
REQ-014 On Load with ValidIn=0, the stage SHALL store a bubble identical to REQ-010 regardless of the other inputs.
REQ-015 The CtrlOut Tnew field SHALL be combinational from the stored Tnew; all other CtrlOut bits SHALL equal the stored bits.
REQ-016 The stage SHALL have a latency of 1 cycle from input to output on Load and no combinational path from any input to any output.
REQ-017 A bubble cycle is any edge after which valid=0 (Flush, or Load with ValidIn=0); a Hold of a bubble also counts.
REQ-018 On each bubble cycle, BubbleCnt SHALL increment by 1, saturating at all-ones with no wrap.
REQ-019 The Tnew arithmetic SHALL be unsigned, TNEW_W bits wide, and SHALL never underflow.
REQ-020 With Flush and Hold both asserted, the result SHALL be a bubble and the held contents SHALL be discarded.
REQ-021 An elaboration-time error SHALL fire if TNEW_LSB+TNEW_W > CTRL_LEN or NUM_LANES < 1.

Reset
REQ-022 Reset assertion SHALL immediately, without waiting for Clk, force: ins=0, pc=RESET_PC, ctrl=0, lanes=0, valid=0, BubbleCnt=0.
REQ-023 While Reset is high, the stage SHALL ignore all edges.
REQ-024 On the first edge after Reset deasserts, the stage SHALL apply normal priority.
REQ-025 Reset asserted mid-Hold SHALL discard the held instruction.
REQ-026 Reset SHALL NOT count as a bubble cycle.

Verification
REQ-027 Load: ValidIn=1, InsIn=32'h0043_2021, PCIn=32'h3004, CtrlIn Tnew=2 -> next cycle ValidOut=1, InsOut=32'h0043_2021, PCOut=32'h3004, CtrlOut Tnew=1 (OUT_DEC=1).
REQ-028 Hold: a stored instruction with Tnew=3, Hold for 4 cycles -> stored Tnew goes 2,1,0,0; InsOut and PCOut are constant; CtrlOut Tnew with OUT_DEC=1 reads 1,0,0,0.
REQ-029 Priority: Flush=1 and Hold=1 on a valid stage -> next cycle ValidOut=0, PCOut=32'h3000, BubbleCnt+1.
REQ-030 Bubble load: ValidIn=0 with InsIn=32'hFFFF_FFFF -> InsOut=0, CtrlOut=0; counter saturation: with CNT_W=4, 20 consecutive Flush cycles -> BubbleCnt=4'hF.
REQ-031 Asynchronous reset: Reset pulsed between edges while the stage is valid -> outputs reach reset values before the next Clk edge, and BubbleCnt=0.
REQ-032 Parameter sweep: NUM_LANES=3, TNEW_LSB=0 -> lane 2 passes 32'hDEAD_BEEF intact, and the Tnew field at bits [2:0] decrements correctly.
